// File: rtl/eyeriss_pkg.sv
// Shared definitions for the PE feeder: default widths, the feeder FSM state
// encoding and the helper that sizes the psum phase of a job.
package eyeriss_pkg;

  localparam int unsigned DataSize   = 8;
  localparam int unsigned MacResSize = 2 * DataSize + 4;
  localparam int unsigned CntWidth   = 8;

  typedef enum logic [3:0] {
    StIdle,
    StLoadW,
    StGapW,
    StLoadA,
    StGapA,
    StStart,
    StCompute,
    StGapC,
    StSums,
    StFlush
  } feeder_state_e;

  // Number of output psums of a 1-D job: acount + 1 - wcount. One extra bit keeps
  // acount = 255, wcount = 1 (Nout = 255) and any intermediate sum from wrapping.
  function automatic logic [CntWidth:0] calc_nout(input logic [CntWidth-1:0] acount,
                                                   input logic [CntWidth-1:0] wcount);
    logic [CntWidth:0] one;
    one    = '0;
    one[0] = 1'b1;
    return ({1'b0, acount} + one) - {1'b0, wcount};
  endfunction

endpackage

// File: rtl/pe_feeder_outslot.sv
// One-entry registered output slot for PE psum results.
//   sums_i       : a sums cycle was issued to the PE this cycle
//   psum_i       : PE result, valid the cycle after a sums cycle
//   out_*        : valid/ready output stream, data held stable while stalled
//   can_accept_o : a sums cycle issued now cannot overwrite an undrained entry
//   idle_o       : nothing in flight and nothing held
module pe_feeder_outslot
  import eyeriss_pkg::*;
#(
  parameter int unsigned Width = MacResSize
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sums_i,
  input  logic [Width-1:0] psum_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  output logic             can_accept_o,
  output logic             idle_o
);

  logic             pend_q;
  logic             valid_q;
  logic [Width-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      pend_q <= sums_i;
      if (pend_q) begin
        valid_q <= 1'b1;
        data_q  <= psum_i;
      end else if (valid_q && out_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  // A result in flight lands one cycle later; only one may be outstanding, and the
  // held entry must leave this cycle so the slot is empty when that result lands.
  assign can_accept_o = !pend_q && (!valid_q || out_ready_i);
  assign idle_o       = !pend_q && !valid_q;
  assign out_valid_o  = valid_q;
  assign out_data_o   = data_q;

endmodule

// File: rtl/pe_feeder.sv
// Initiator side of the PE load/compute/psum interface, one per PE.
//   clk, nrst                 : clock, asynchronous active-low reset (aborts a job)
//   cfg_acount / cfg_wcount   : job sizes, sampled when a job is accepted
//   job_start_i / busy_o      : job request (IDLE only) / not-idle indication
//   job_done_o / job_err_o    : end-of-job pulse / illegal-config pulse with done
//   w_*, a_*, ps_*            : weight, activation and incoming psum streams
//   out_*                     : outgoing psum stream with backpressure
//   pe_*                      : PE load/start/sums control and data, flag_done and result
module pe_feeder
  import eyeriss_pkg::*;
#(
  parameter int unsigned dataSize   = DataSize,
  parameter int unsigned macResSize = MacResSize,
  parameter int unsigned cntWidth   = CntWidth
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [cntWidth-1:0]   cfg_acount,
  input  logic [cntWidth-1:0]   cfg_wcount,
  input  logic                  job_start_i,
  output logic                  busy_o,
  output logic                  job_done_o,
  output logic                  job_err_o,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic [dataSize-1:0]   w_data_i,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [dataSize-1:0]   a_data_i,
  input  logic                  ps_valid_i,
  output logic                  ps_ready_o,
  input  logic [macResSize-1:0] ps_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [macResSize-1:0] out_data_o,
  output logic [dataSize-1:0]   pe_weights_o,
  output logic [dataSize-1:0]   pe_acts_o,
  output logic [macResSize-1:0] pe_psum_o,
  output logic                  pe_ctrl_loadw,
  output logic                  pe_ctrl_loada,
  output logic [cntWidth-1:0]   pe_ctrl_acount,
  output logic [cntWidth-1:0]   pe_ctrl_wcount,
  output logic                  pe_ctrl_start,
  output logic                  pe_ctrl_sums,
  input  logic                  pe_flag_done_i,
  input  logic [macResSize-1:0] pe_psum_i
);

  feeder_state_e         state_q;
  logic [cntWidth-1:0]   acnt_q;
  logic [cntWidth-1:0]   wcnt_q;
  logic [cntWidth-1:0]   beat_q;
  logic [cntWidth:0]     nout_q;
  logic [cntWidth:0]     scnt_q;
  logic                  w_ready_q;
  logic                  a_ready_q;
  logic                  loadw_q;
  logic                  loada_q;
  logic                  start_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [dataSize-1:0]   weights_q;
  logic [dataSize-1:0]   acts_q;

  logic                  w_hs;
  logic                  a_hs;
  logic                  sums;
  logic                  cfg_bad;
  logic                  can_accept;
  logic                  slot_idle;

  assign w_hs    = w_valid_i && w_ready_q;
  assign a_hs    = a_valid_i && a_ready_q;
  assign cfg_bad = (cfg_wcount == '0) || (cfg_acount == '0) || (cfg_wcount > cfg_acount);

  // The sums handshake must see this cycle's ps_valid_i and out_ready_i, so it is
  // decoded from the registered state rather than registered itself.
  assign sums = (state_q == StSums) && ps_valid_i && can_accept;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StIdle;
      acnt_q    <= '0;
      wcnt_q    <= '0;
      beat_q    <= '0;
      nout_q    <= '0;
      scnt_q    <= '0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      loadw_q   <= 1'b0;
      loada_q   <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      weights_q <= '0;
      acts_q    <= '0;
    end else begin
      loadw_q <= 1'b0;
      loada_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (job_start_i) begin
            acnt_q <= cfg_acount;
            wcnt_q <= cfg_wcount;
            nout_q <= calc_nout(cfg_acount, cfg_wcount);
            if (cfg_bad) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state_q   <= StLoadW;
              busy_q    <= 1'b1;
              w_ready_q <= 1'b1;
              beat_q    <= '0;
            end
          end
        end
        // Ready drops on the last handshake; the state lingers one cycle so the
        // final load strobe lands inside LOADW and the gap cycle stays quiet.
        StLoadW: begin
          if (w_hs) begin
            weights_q <= w_data_i;
            loadw_q   <= 1'b1;
            beat_q    <= beat_q + cntWidth'(1);
            if (beat_q + cntWidth'(1) == wcnt_q) w_ready_q <= 1'b0;
          end else if (!w_ready_q) begin
            state_q <= StGapW;
            beat_q  <= '0;
          end
        end
        StGapW: begin
          state_q   <= StLoadA;
          a_ready_q <= 1'b1;
        end
        StLoadA: begin
          if (a_hs) begin
            acts_q  <= a_data_i;
            loada_q <= 1'b1;
            beat_q  <= beat_q + cntWidth'(1);
            if (beat_q + cntWidth'(1) == acnt_q) a_ready_q <= 1'b0;
          end else if (!a_ready_q) begin
            state_q <= StGapA;
            beat_q  <= '0;
          end
        end
        StGapA: begin
          state_q <= StStart;
          start_q <= 1'b1;
        end
        StStart: begin
          state_q <= StCompute;
        end
        StCompute: begin
          if (pe_flag_done_i) state_q <= StGapC;
        end
        StGapC: begin
          state_q <= StSums;
          scnt_q  <= '0;
        end
        StSums: begin
          if (sums) begin
            scnt_q <= scnt_q + (cntWidth + 1)'(1);
            if (scnt_q + (cntWidth + 1)'(1) == nout_q) state_q <= StFlush;
          end
        end
        StFlush: begin
          if (slot_idle) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  pe_feeder_outslot #(
    .Width (macResSize)
  ) u_outslot (
    .clk_i        (clk),
    .rst_ni       (nrst),
    .sums_i       (sums),
    .psum_i       (pe_psum_i),
    .out_ready_i  (out_ready_i),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .can_accept_o (can_accept),
    .idle_o       (slot_idle)
  );

  assign busy_o         = busy_q;
  assign job_done_o     = done_q;
  assign job_err_o      = err_q;
  assign w_ready_o      = w_ready_q;
  assign a_ready_o      = a_ready_q;
  assign ps_ready_o     = sums;
  assign pe_ctrl_sums   = sums;
  assign pe_psum_o      = sums ? ps_data_i : '0;
  assign pe_weights_o   = weights_q;
  assign pe_acts_o      = acts_q;
  assign pe_ctrl_loadw  = loadw_q;
  assign pe_ctrl_loada  = loada_q;
  assign pe_ctrl_start  = start_q;
  assign pe_ctrl_acount = acnt_q;
  assign pe_ctrl_wcount = wcnt_q;

endmodule
